// File: rtl/operand_fetch_stage_if.sv
// ID-side operand fetch bus: decode inputs, register file
// read port, forwarding sources and the ID/EX register outputs.
interface operand_fetch_stage_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  logic            id_valid;
  logic [XLEN-1:0] id_pc;
  logic [AW-1:0]   id_rs1;
  logic [AW-1:0]   id_rs2;
  logic            id_rs1_used;
  logic            id_rs2_used;
  logic [AW-1:0]   id_rd;
  logic            id_reg_write;
  logic            id_mem_read;
  logic [AW-1:0]   rf_read1;
  logic [AW-1:0]   rf_read2;
  logic [XLEN-1:0] rf_read_data1;
  logic [XLEN-1:0] rf_read_data2;
  logic [XLEN-1:0] ex_result;
  logic            mem_reg_write;
  logic [AW-1:0]   mem_rd;
  logic [XLEN-1:0] mem_data;
  logic            wb_reg_write;
  logic [AW-1:0]   wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            ex_hold;
  logic            flush;
  logic            stall;
  logic            ex_valid;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_op_a;
  logic [XLEN-1:0] ex_op_b;
  logic [AW-1:0]   ex_rd;
  logic            ex_reg_write;
  logic            ex_mem_read;

  modport slave (
    input  id_valid, id_pc, id_rs1, id_rs2,
    input  id_rs1_used, id_rs2_used, id_rd,
    input  id_reg_write, id_mem_read,
    output rf_read1, rf_read2,
    input  rf_read_data1, rf_read_data2,
    input  ex_result,
    input  mem_reg_write, mem_rd, mem_data,
    input  wb_reg_write, wb_rd, wb_data,
    input  ex_hold, flush,
    output stall,
    output ex_valid, ex_pc, ex_op_a, ex_op_b,
    output ex_rd, ex_reg_write, ex_mem_read
  );

  modport master (
    output id_valid, id_pc, id_rs1, id_rs2,
    output id_rs1_used, id_rs2_used, id_rd,
    output id_reg_write, id_mem_read,
    input  rf_read1, rf_read2,
    output rf_read_data1, rf_read_data2,
    output ex_result,
    output mem_reg_write, mem_rd, mem_data,
    output wb_reg_write, wb_rd, wb_data,
    output ex_hold, flush,
    input  stall,
    input  ex_valid, ex_pc, ex_op_a, ex_op_b,
    input  ex_rd, ex_reg_write, ex_mem_read
  );
endinterface

// File: rtl/operand_fetch_stage.sv
// Operand fetch: RF read, EX/MEM/WB bypass, load-use stall
// and the ID/EX pipeline register.
module operand_fetch_stage #(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input logic                  clk,
  input logic                  rst,
  operand_fetch_stage_if.slave bus
);
  logic            ex_valid_q, ex_valid_d;
  logic [XLEN-1:0] ex_pc_q, ex_pc_d;
  logic [XLEN-1:0] ex_op_a_q, ex_op_a_d;
  logic [XLEN-1:0] ex_op_b_q, ex_op_b_d;
  logic [AW-1:0]   ex_rd_q, ex_rd_d;
  logic            ex_rw_q, ex_rw_d;
  logic            ex_mr_q, ex_mr_d;

  logic            ex_fwd;
  logic            hz;
  logic [XLEN-1:0] op_a, op_b;

  // A load in EX has no result yet, so it never bypasses.
  assign ex_fwd = ex_valid_q & ex_rw_q & ~ex_mr_q;

  function automatic logic [XLEN-1:0] pick(
    input logic [AW-1:0]   idx,
    input logic [XLEN-1:0] rfd
  );
    if (idx == '0)
      pick = '0;
    else if (ex_fwd && ex_rd_q == idx)
      pick = bus.ex_result;
    else if (bus.mem_reg_write && bus.mem_rd == idx)
      pick = bus.mem_data;
    else if (bus.wb_reg_write && bus.wb_rd == idx)
      pick = bus.wb_data;
    else
      pick = rfd;
  endfunction

  // Forwarded operand select, youngest producer first.
  always_comb begin
    op_a = pick(bus.id_rs1, bus.rf_read_data1);
    op_b = pick(bus.id_rs2, bus.rf_read_data2);
  end

  // Load-use hazard against the load sitting in EX.
  always_comb begin
    hz = bus.id_valid & ex_valid_q & ex_mr_q
       & (ex_rd_q != '0)
       & ((bus.id_rs1_used & (ex_rd_q == bus.id_rs1))
        | (bus.id_rs2_used & (ex_rd_q == bus.id_rs2)));
  end

  assign bus.stall    = (hz | bus.ex_hold) & ~bus.flush;
  assign bus.rf_read1 = bus.id_rs1;
  assign bus.rf_read2 = bus.id_rs2;

  // ID/EX next state: hold, then bubble, then capture.
  always_comb begin
    ex_valid_d = ex_valid_q;
    ex_pc_d    = ex_pc_q;
    ex_op_a_d  = ex_op_a_q;
    ex_op_b_d  = ex_op_b_q;
    ex_rd_d    = ex_rd_q;
    ex_rw_d    = ex_rw_q;
    ex_mr_d    = ex_mr_q;
    if (bus.ex_hold) begin
      ex_valid_d = ex_valid_q;
    end else if (bus.flush || hz) begin
      ex_valid_d = 1'b0;
      ex_rw_d    = 1'b0;
      ex_mr_d    = 1'b0;
    end else begin
      ex_valid_d = bus.id_valid;
      ex_pc_d    = bus.id_pc;
      ex_op_a_d  = op_a;
      ex_op_b_d  = op_b;
      ex_rd_d    = bus.id_rd;
      ex_rw_d    = bus.id_valid & bus.id_reg_write;
      ex_mr_d    = bus.id_valid & bus.id_mem_read;
    end
  end

  // ID/EX register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q <= 1'b0;
      ex_pc_q    <= '0;
      ex_op_a_q  <= '0;
      ex_op_b_q  <= '0;
      ex_rd_q    <= '0;
      ex_rw_q    <= 1'b0;
      ex_mr_q    <= 1'b0;
    end else begin
      ex_valid_q <= ex_valid_d;
      ex_pc_q    <= ex_pc_d;
      ex_op_a_q  <= ex_op_a_d;
      ex_op_b_q  <= ex_op_b_d;
      ex_rd_q    <= ex_rd_d;
      ex_rw_q    <= ex_rw_d;
      ex_mr_q    <= ex_mr_d;
    end
  end

  assign bus.ex_valid     = ex_valid_q;
  assign bus.ex_pc        = ex_pc_q;
  assign bus.ex_op_a      = ex_op_a_q;
  assign bus.ex_op_b      = ex_op_b_q;
  assign bus.ex_rd        = ex_rd_q;
  assign bus.ex_reg_write = ex_rw_q;
  assign bus.ex_mem_read  = ex_mr_q;
endmodule

// File: tb/tb_operand_fetch_stage.sv
// Bench for operand_fetch_stage: directed plan steps, then
// random traffic against a behavioural ID/EX model.
module tb_operand_fetch_stage;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  operand_fetch_stage_if #(.XLEN(32), .AW(5)) bus ();
  operand_fetch_stage #(.XLEN(32), .AW(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks = 0;
  int failures = 0;

  logic        m_valid, m_rw, m_mr;
  logic [31:0] m_pc, m_a, m_b;
  logic [4:0]  m_rd;
  logic        last_stall;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Value a source register should read in this cycle.
  function automatic logic [31:0] want(input logic [4:0] r,
                                       input logic [31:0] rf);
    if (r == 0) return 32'h0;
    if (m_valid && m_rw && !m_mr && m_rd == r) return bus.ex_result;
    if (bus.mem_reg_write && bus.mem_rd == r) return bus.mem_data;
    if (bus.wb_reg_write && bus.wb_rd == r) return bus.wb_data;
    return rf;
  endfunction

  function automatic logic load_use();
    logic dep;
    dep = (bus.id_rs1_used && bus.id_rs1 == m_rd)
       || (bus.id_rs2_used && bus.id_rs2 == m_rd);
    return bus.id_valid && m_valid && m_mr && m_rd != 0 && dep;
  endfunction

  // One clock: check combinational outputs, advance model,
  // then check the registered outputs.
  task automatic cycle();
    logic        hz, nv, nrw, nmr;
    logic [31:0] npc, na, nb;
    logic [4:0]  nrd;
    #1;
    hz = load_use();
    last_stall = bus.stall;
    chk("stall", {31'b0, bus.stall},
        {31'b0, (hz || bus.ex_hold) && !bus.flush});
    chk("rf_read1", {27'b0, bus.rf_read1}, {27'b0, bus.id_rs1});
    chk("rf_read2", {27'b0, bus.rf_read2}, {27'b0, bus.id_rs2});
    nv = m_valid; npc = m_pc; na = m_a; nb = m_b;
    nrd = m_rd; nrw = m_rw; nmr = m_mr;
    if (rst) begin
      nv = 0; npc = 0; na = 0; nb = 0; nrd = 0; nrw = 0; nmr = 0;
    end else if (bus.ex_hold) begin
      nv = m_valid;
    end else if (bus.flush || hz) begin
      nv = 0; nrw = 0; nmr = 0;
    end else begin
      nv  = bus.id_valid;
      npc = bus.id_pc;
      na  = want(bus.id_rs1, bus.rf_read_data1);
      nb  = want(bus.id_rs2, bus.rf_read_data2);
      nrd = bus.id_rd;
      nrw = bus.id_valid && bus.id_reg_write;
      nmr = bus.id_valid && bus.id_mem_read;
    end
    @(posedge clk);
    m_valid = nv; m_pc = npc; m_a = na; m_b = nb;
    m_rd = nrd; m_rw = nrw; m_mr = nmr;
    #1;
    chk("ex_valid", {31'b0, bus.ex_valid}, {31'b0, m_valid});
    chk("ex_reg_write", {31'b0, bus.ex_reg_write}, {31'b0, m_rw});
    chk("ex_mem_read", {31'b0, bus.ex_mem_read}, {31'b0, m_mr});
    if (m_valid || rst) begin
      chk("ex_pc", bus.ex_pc, m_pc);
      chk("ex_op_a", bus.ex_op_a, m_a);
      chk("ex_op_b", bus.ex_op_b, m_b);
      chk("ex_rd", {27'b0, bus.ex_rd}, {27'b0, m_rd});
    end
  endtask

  task automatic idle();
    rst = 0;
    bus.id_valid = 1; bus.id_pc = 32'h100;
    bus.id_rs1 = 0; bus.id_rs2 = 0;
    bus.id_rs1_used = 1; bus.id_rs2_used = 1;
    bus.id_rd = 0; bus.id_reg_write = 0; bus.id_mem_read = 0;
    bus.rf_read_data1 = 0; bus.rf_read_data2 = 0;
    bus.ex_result = 0;
    bus.mem_reg_write = 0; bus.mem_rd = 0; bus.mem_data = 0;
    bus.wb_reg_write = 0; bus.wb_rd = 0; bus.wb_data = 0;
    bus.ex_hold = 0; bus.flush = 0;
  endtask

  task automatic put_load();
    idle();
    bus.id_rd = 4; bus.id_reg_write = 1; bus.id_mem_read = 1;
    cycle();
    idle();
    bus.id_rs1 = 4;
  endtask

  initial begin
    m_valid = 0; m_pc = 0; m_a = 0; m_b = 0;
    m_rd = 0; m_rw = 0; m_mr = 0;
    idle();
    rst = 1;
    bus.id_rd = 9; bus.id_reg_write = 1; bus.id_mem_read = 1;
    bus.id_pc = 32'h44;
    @(negedge clk);
    cycle();
    cycle();
    chk("rst_valid", {31'b0, bus.ex_valid}, 32'h0);
    chk("rst_pc", bus.ex_pc, 32'h0);
    chk("rst_stall", {31'b0, bus.stall}, 32'h0);

    idle();
    bus.id_rs1 = 3; bus.rf_read_data1 = 32'h11;
    cycle();
    chk("first_op_a", bus.ex_op_a, 32'h11);
    chk("first_valid", {31'b0, bus.ex_valid}, 32'h1);

    idle();
    bus.id_rs2 = 5; bus.wb_reg_write = 1;
    bus.wb_rd = 5; bus.wb_data = 32'habcdef01;
    cycle();
    chk("wb_bypass", bus.ex_op_b, 32'habcdef01);

    idle();
    bus.id_rd = 7; bus.id_reg_write = 1;
    cycle();
    bus.id_rs1 = 7; bus.ex_result = 32'h1;
    bus.mem_reg_write = 1; bus.mem_rd = 7; bus.mem_data = 32'h2;
    bus.wb_reg_write = 1; bus.wb_rd = 7; bus.wb_data = 32'h3;
    bus.rf_read_data1 = 32'h4;
    cycle();
    chk("prio_ex", bus.ex_op_a, 32'h1);
    bus.id_rs1 = 0;
    cycle();
    chk("prio_x0", bus.ex_op_a, 32'h0);

    put_load();
    cycle();
    chk("lu_stall", {31'b0, last_stall}, 32'h1);
    chk("lu_bubble", {31'b0, bus.ex_valid}, 32'h0);
    bus.mem_reg_write = 1; bus.mem_rd = 4;
    bus.mem_data = 32'hdeadbeef;
    cycle();
    chk("lu_nostall", {31'b0, last_stall}, 32'h0);
    chk("lu_fwd", bus.ex_op_a, 32'hdeadbeef);

    put_load();
    bus.id_rs1_used = 0;
    cycle();
    chk("unused_stall", {31'b0, last_stall}, 32'h0);
    chk("unused_valid", {31'b0, bus.ex_valid}, 32'h1);

    put_load();
    bus.flush = 1;
    cycle();
    chk("flush_stall", {31'b0, last_stall}, 32'h0);
    chk("flush_valid", {31'b0, bus.ex_valid}, 32'h0);

    idle();
    bus.id_pc = 32'h2468;
    cycle();
    bus.ex_hold = 1; bus.id_pc = 32'h9999;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("hold_stall", {31'b0, last_stall}, 32'h1);
      chk("hold_pc", bus.ex_pc, 32'h2468);
    end
    bus.flush = 1;
    cycle();
    chk("holdflush_stall", {31'b0, last_stall}, 32'h0);
    chk("holdflush_valid", {31'b0, bus.ex_valid}, 32'h1);

    put_load();
    cycle();
    rst = 1;
    cycle();
    chk("rst_midstall", {31'b0, bus.ex_valid}, 32'h0);

    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 39) == 0);
      bus.id_valid = ($urandom_range(0, 7) != 0);
      bus.id_pc = $urandom;
      bus.id_rs1 = 5'($urandom_range(0, 7));
      bus.id_rs2 = 5'($urandom_range(0, 7));
      bus.id_rs1_used = $urandom_range(0, 1) == 1;
      bus.id_rs2_used = $urandom_range(0, 1) == 1;
      bus.id_rd = 5'($urandom_range(0, 7));
      bus.id_reg_write = $urandom_range(0, 1) == 1;
      bus.id_mem_read = ($urandom_range(0, 2) == 0);
      bus.rf_read_data1 = $urandom;
      bus.rf_read_data2 = $urandom;
      bus.ex_result = $urandom;
      bus.mem_reg_write = $urandom_range(0, 1) == 1;
      bus.mem_rd = 5'($urandom_range(0, 7));
      bus.mem_data = $urandom;
      bus.wb_reg_write = $urandom_range(0, 1) == 1;
      bus.wb_rd = 5'($urandom_range(0, 7));
      bus.wb_data = $urandom;
      bus.ex_hold = ($urandom_range(0, 5) == 0);
      bus.flush = ($urandom_range(0, 7) == 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
